// File: rtl/stme_host_port_if.sv
// Beat/block handshake bundle for stme_host_port.
//   blk_in_*  : upstream 128-bit ciphertext block, valid/ready
//   dp_in_*   : 64-bit beats toward the encrypted-stream datapath
//   dp_out_*  : 64-bit result beats from the datapath (no backpressure)
//   blk_out_* : reassembled 128-bit result blocks, valid/ready
// master = the host port itself, slave = the surrounding environment.
interface stme_host_port_if;
  logic         blk_in_valid;
  logic         blk_in_ready;
  logic [127:0] blk_in_data;
  logic         dp_in_valid;
  logic [63:0]  dp_in_data;
  logic         dp_out_valid;
  logic [63:0]  dp_out_data;
  logic         blk_out_valid;
  logic         blk_out_ready;
  logic [127:0] blk_out_data;

  modport master (
    input  blk_in_valid, blk_in_data, dp_out_valid, dp_out_data, blk_out_ready,
    output blk_in_ready, dp_in_valid, dp_in_data, blk_out_valid, blk_out_data
  );

  modport slave (
    output blk_in_valid, blk_in_data, dp_out_valid, dp_out_data, blk_out_ready,
    input  blk_in_ready, dp_in_valid, dp_in_data, blk_out_valid, blk_out_data
  );
endinterface

// File: rtl/stme_host_port.sv
// Host-side endpoint for the 64-bit encrypted-stream datapath.
// TX splits each accepted 128-bit block into a low beat then a high beat.
// RX pairs result beats back into 128-bit blocks and queues them in a FIFO.
// TX is credit-gated so every block in flight has a guaranteed FIFO slot.
// Ports:
//   clock, reset  : rising-edge clock, async active-high reset
//   bus           : stme_host_port_if.master (block and beat handshakes)
//   credits       : free credits (FIFO_DEPTH minus in-flight and buffered)
//   err_frame     : sticky, low beat not followed by a high beat
//   err_overflow  : sticky, beat pair completed while FIFO full
//
// state  | meaning
// S_IDLE | no beat on dp_in this cycle
// S_LO   | low half of the latched block on dp_in
// S_HI   | high half on dp_in; a new block may be accepted now
module stme_host_port #(
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  stme_host_port_if.master    bus,
  output logic [CW-1:0]       credits,
  output logic                err_frame,
  output logic                err_overflow
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} tx_state_e;

  tx_state_e      state_q, state_d;
  logic [127:0]   blk_q, blk_d;
  logic           dp_in_valid_q, dp_in_valid_d;
  logic [63:0]    dp_in_data_q, dp_in_data_d;
  logic [CW-1:0]  credits_q, credits_d;
  logic           rx_phase_q, rx_phase_d;
  logic [63:0]    rx_lo_q, rx_lo_d;
  logic [127:0]   mem_q [FIFO_DEPTH];
  logic [127:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           err_frame_q, err_frame_d;
  logic           err_overflow_q, err_overflow_d;

  logic in_ready, accept, pop, push, push_ok, fifo_full, credit_ret;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = ((state_q == S_IDLE) || (state_q == S_HI)) && (credits_q != '0);
  assign accept    = bus.blk_in_valid && in_ready;
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign pop       = (count_q != '0) && bus.blk_out_ready;
  assign push      = rx_phase_q && bus.dp_out_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_ok   = push && (!fifo_full || pop);
  // Blocks lost to framing errors never return a credit; saturate anyway.
  assign credit_ret = pop && (credits_q != CW'(FIFO_DEPTH));

  always_comb begin
    state_d       = state_q;
    blk_d         = blk_q;
    dp_in_valid_d = dp_in_valid_q;
    dp_in_data_d  = dp_in_data_q;
    case (state_q)
      S_LO: begin
        state_d       = S_HI;
        dp_in_valid_d = 1'b1;
        dp_in_data_d  = blk_q[127:64];
      end
      S_IDLE, S_HI: begin
        if (accept) begin
          state_d       = S_LO;
          blk_d         = bus.blk_in_data;
          dp_in_valid_d = 1'b1;
          dp_in_data_d  = bus.blk_in_data[63:0];
        end else begin
          state_d       = S_IDLE;
          dp_in_valid_d = 1'b0;
        end
      end
      default: begin
        state_d       = S_IDLE;
        dp_in_valid_d = 1'b0;
      end
    endcase

    credits_d = credits_q;
    if (accept && !credit_ret)      credits_d = credits_q - 1'b1;
    else if (!accept && credit_ret) credits_d = credits_q + 1'b1;
  end

  always_comb begin
    rx_phase_d     = rx_phase_q;
    rx_lo_d        = rx_lo_q;
    err_frame_d    = err_frame_q;
    err_overflow_d = err_overflow_q;
    if (!rx_phase_q) begin
      if (bus.dp_out_valid) begin
        rx_lo_d    = bus.dp_out_data;
        rx_phase_d = 1'b1;
      end
    end else begin
      rx_phase_d = 1'b0;
      if (!bus.dp_out_valid) err_frame_d    = 1'b1;
      else if (!push_ok)     err_overflow_d = 1'b1;
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {bus.dp_out_data, rx_lo_q};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      blk_q          <= '0;
      dp_in_valid_q  <= 1'b0;
      dp_in_data_q   <= '0;
      credits_q      <= CW'(FIFO_DEPTH);
      rx_phase_q     <= 1'b0;
      rx_lo_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      err_frame_q    <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      blk_q          <= blk_d;
      dp_in_valid_q  <= dp_in_valid_d;
      dp_in_data_q   <= dp_in_data_d;
      credits_q      <= credits_d;
      rx_phase_q     <= rx_phase_d;
      rx_lo_q        <= rx_lo_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      err_frame_q    <= err_frame_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign bus.blk_in_ready  = in_ready;
  assign bus.dp_in_valid   = dp_in_valid_q;
  assign bus.dp_in_data    = dp_in_data_q;
  assign bus.blk_out_valid = (count_q != '0);
  assign bus.blk_out_data  = mem_q[rd_ptr_q];
  assign credits           = credits_q;
  assign err_frame         = err_frame_q;
  assign err_overflow      = err_overflow_q;
endmodule

// File: tb/tb_stme_host_port.sv
module tb_stme_host_port;
  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] credits;
  logic       err_frame, err_overflow;

  always #5 clock = ~clock;

  stme_host_port_if ifc();

  stme_host_port #(.FIFO_DEPTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (ifc),
    .credits      (credits),
    .err_frame    (err_frame),
    .err_overflow (err_overflow)
  );

  // Loopback datapath model: returns each beat inverted, two negedges later.
  logic        lb_en = 1'b0;
  logic        lb_v1 = 1'b0, lb_v2 = 1'b0;
  logic [63:0] lb_d1 = '0, lb_d2 = '0;
  logic        man_valid = 1'b0;
  logic [63:0] man_data = '0;

  always @(negedge clock) begin
    lb_v2 = lb_v1;
    lb_d2 = lb_d1;
    lb_v1 = ifc.dp_in_valid;
    lb_d1 = ifc.dp_in_data;
  end

  assign ifc.dp_out_valid = lb_en ? lb_v2  : man_valid;
  assign ifc.dp_out_data  = lb_en ? ~lb_d2 : man_data;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_out(input string tag);
    int k = 0;
    while (!ifc.blk_out_valid && k < 20) begin
      tick();
      k++;
    end
    check(tag, ifc.blk_out_valid, 1'b1);
  endtask

  task automatic push_pair(input logic [63:0] lo, input logic [63:0] hi);
    man_valid = 1'b1;
    man_data  = lo;
    tick();
    man_data  = hi;
    tick();
    man_valid = 1'b0;
  endtask

  function automatic logic [127:0] mk(input int k);
    return {64'hB000_0000_0000_0000 + 64'(k), 64'hA000_0000_0000_0000 + 64'(k)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a, blk, c, d;
    logic [127:0] bv [6];
    int idx, pidx, acc_cnt, vcnt;

    reset = 1'b1;
    ifc.blk_in_valid  = 1'b0;
    ifc.blk_in_data   = '0;
    ifc.blk_out_ready = 1'b0;
    lb_en = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset state
    check("rst_dp_valid", ifc.dp_in_valid, 1'b0);
    check("rst_out_valid", ifc.blk_out_valid, 1'b0);
    check("rst_credits", credits, 3'd4);
    check("rst_err_frame", err_frame, 1'b0);
    check("rst_err_ovf", err_overflow, 1'b0);
    check("rst_ready", ifc.blk_in_ready, 1'b1);

    // single block through the loopback
    a = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
    ifc.blk_in_valid = 1'b1;
    ifc.blk_in_data  = a;
    tick();
    ifc.blk_in_valid = 1'b0;
    check("a_lo_valid", ifc.dp_in_valid, 1'b1);
    check("a_lo_data", ifc.dp_in_data, 64'h2222_2222_2222_2222);
    check("a_credits_dec", credits, 3'd3);
    tick();
    check("a_hi_valid", ifc.dp_in_valid, 1'b1);
    check("a_hi_data", ifc.dp_in_data, 64'h1111_1111_1111_1111);
    tick();
    check("a_idle", ifc.dp_in_valid, 1'b0);
    wait_out("a_out_wait");
    check("a_out_data", ifc.blk_out_data, {64'hEEEE_EEEE_EEEE_EEEE, 64'hDDDD_DDDD_DDDD_DDDD});
    ifc.blk_out_ready = 1'b1;
    tick();
    ifc.blk_out_ready = 1'b0;
    check("a_popped", ifc.blk_out_valid, 1'b0);
    check("a_credits_ret", credits, 3'd4);

    // back-to-back six blocks, consumer stalled
    for (int i = 0; i < 6; i++)
      bv[i] = {64'h5000_0000_0000_0000 + 64'(i), 64'h6000_0000_0000_0000 + 64'(i)};
    idx = 0; acc_cnt = 0; vcnt = 0;
    for (int t = 0; t < 16; t++) begin
      ifc.blk_in_valid = (idx < 6);
      ifc.blk_in_data  = (idx < 6) ? bv[idx] : '0;
      if (ifc.blk_in_valid && ifc.blk_in_ready) begin
        idx++;
        acc_cnt++;
      end
      tick();
      if (t < 8 && ifc.dp_in_valid) vcnt++;
    end
    check("b2b_accepted", 128'(acc_cnt), 128'd4);
    check("b2b_no_gap", 128'(vcnt), 128'd8);
    check("b2b_credits0", credits, 3'd0);
    check("b2b_ready0", ifc.blk_in_ready, 1'b0);
    check("b2b_full_valid", ifc.blk_out_valid, 1'b1);

    ifc.blk_out_ready = 1'b1;
    pidx = 0;
    for (int t = 0; t < 80 && pidx < 6; t++) begin
      ifc.blk_in_valid = (idx < 6);
      ifc.blk_in_data  = (idx < 6) ? bv[idx] : '0;
      if (ifc.blk_in_valid && ifc.blk_in_ready) idx++;
      if (ifc.blk_out_valid) begin
        check($sformatf("b2b_pop%0d", pidx), ifc.blk_out_data, ~bv[pidx]);
        pidx++;
      end
      tick();
    end
    ifc.blk_in_valid  = 1'b0;
    ifc.blk_out_ready = 1'b0;
    check("b2b_all_popped", 128'(pidx), 128'd6);
    check("b2b_credits4", credits, 3'd4);
    check("b2b_empty", ifc.blk_out_valid, 1'b0);
    check("b2b_no_ovf", err_overflow, 1'b0);

    // full FIFO: pop and high-beat push on the same edge
    lb_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      blk = mk(k);
      push_pair(blk[63:0], blk[127:64]);
    end
    blk = mk(4);
    man_valid = 1'b1;
    man_data  = blk[63:0];
    tick();
    man_data = blk[127:64];
    ifc.blk_out_ready = 1'b1;
    check("full_head0", ifc.blk_out_data, mk(0));
    tick();
    man_valid = 1'b0;
    ifc.blk_out_ready = 1'b0;
    check("full_no_ovf", err_overflow, 1'b0);
    ifc.blk_out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("full_order%0d", k), ifc.blk_out_data, mk(k));
      tick();
    end
    ifc.blk_out_ready = 1'b0;
    check("full_drained", ifc.blk_out_valid, 1'b0);

    // framing error: lone low beat
    man_valid = 1'b1;
    man_data  = 64'hDEAD_BEEF_0000_0001;
    tick();
    man_valid = 1'b0;
    tick();
    check("frm_err", err_frame, 1'b1);
    check("frm_no_push", ifc.blk_out_valid, 1'b0);
    push_pair(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    check("frm_next_valid", ifc.blk_out_valid, 1'b1);
    check("frm_next_data", ifc.blk_out_data, {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF});
    ifc.blk_out_ready = 1'b1;
    tick();
    ifc.blk_out_ready = 1'b0;
    check("frm_sticky", err_frame, 1'b1);

    // overflow: fifth pair with FIFO full and no pop
    for (int k = 10; k < 15; k++) begin
      blk = mk(k);
      push_pair(blk[63:0], blk[127:64]);
    end
    check("ovf_set", err_overflow, 1'b1);
    check("ovf_head", ifc.blk_out_data, mk(10));

    // async reset between LO and HI beats
    lb_en = 1'b1;
    c = {64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
    ifc.blk_in_valid = 1'b1;
    ifc.blk_in_data  = c;
    tick();
    ifc.blk_in_valid = 1'b0;
    check("rr_lo_valid", ifc.dp_in_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rr_async_drop", ifc.dp_in_valid, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("rr_credits", credits, 3'd4);
    check("rr_empty", ifc.blk_out_valid, 1'b0);
    check("rr_err_frame", err_frame, 1'b0);
    check("rr_err_ovf", err_overflow, 1'b0);
    d = {64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    ifc.blk_in_valid = 1'b1;
    ifc.blk_in_data  = d;
    tick();
    ifc.blk_in_valid = 1'b0;
    check("rr_next_lo", ifc.dp_in_data, 64'h4444_4444_4444_4444);
    wait_out("rr_out_wait");
    check("rr_out_data", ifc.blk_out_data, {64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB});
    check("rr_no_frame", err_frame, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
